// File: rtl/ped_matrix_driver_if.sv
// rtl/ped_matrix_driver_if.sv - phase inputs and LED matrix outputs of the pedestrian matrix driver
interface ped_matrix_driver_if;
  logic       walk_en;
  logic [5:0] remaining;
  logic [7:0] vert;
  logic [7:0] hori;
  logic [1:0] state;
  logic [1:0] frame;

  modport master (
    output walk_en, remaining,
    input  vert, hori, state, frame
  );

  modport slave (
    input  walk_en, remaining,
    output vert, hori, state, frame
  );
endinterface

// File: rtl/ped_matrix_driver.sv
// rtl/ped_matrix_driver.sv - row-scanned 8x8 walking-man animation driven by the pedestrian phase
module ped_matrix_driver #(
  parameter int ROW_DIV      = 2000,
  parameter int FRAME_SWEEPS = 16,
  parameter int BLINK_SWEEPS = 32,
  parameter int HURRY_SEC    = 5
) (
  input  logic                clk,
  input  logic                reset,
  ped_matrix_driver_if.slave  bus
);

  localparam int DW           = $clog2(ROW_DIV);
  localparam int FW           = $clog2(FRAME_SWEEPS + 1);
  localparam int BW           = $clog2(BLINK_SWEEPS + 1);
  localparam int HURRY_FRAMES = (FRAME_SWEEPS / 2 >= 1) ? FRAME_SWEEPS / 2 : 1;

  // Row 0 sits in the most significant byte of each frame word.
  localparam logic [63:0] GLYPH_F0 = 64'h18183C5A18244200;
  localparam logic [63:0] GLYPH_F1 = 64'h18183C3A58284800;
  localparam logic [63:0] GLYPH_F2 = 64'h18183C1C18181800;
  localparam logic [63:0] GLYPH_F3 = 64'h18183C5C1A141200;
  localparam logic [3:0][63:0] GLYPHS = {GLYPH_F3, GLYPH_F2, GLYPH_F1, GLYPH_F0};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WALK  = 2'b01,
    HURRY = 2'b10
  } state_t;

  state_t          st, st_nx;
  logic [DW-1:0]   div;
  logic [2:0]      row;
  logic [1:0]      frame, frame_nx;
  logic [FW-1:0]   fcnt, fcnt_nx, fcnt_lim;
  logic [BW-1:0]   bcnt, bcnt_nx;
  logic            vis, vis_nx;
  logic [7:0]      vert_r, hori_r;
  logic            row_end, sweep, hurry_zone;

  function automatic logic [7:0] glyph(input logic [1:0] f, input logic [2:0] r);
    return GLYPHS[f][63 - 8 * r -: 8];
  endfunction

  assign row_end    = (div == DW'(ROW_DIV - 1));
  assign sweep      = row_end && (row == 3'd7);
  assign hurry_zone = (bus.remaining <= 6'(HURRY_SEC));
  assign fcnt_lim   = (st == HURRY) ? FW'(HURRY_FRAMES - 1) : FW'(FRAME_SWEEPS - 1);

  always_comb begin
    st_nx = st;
    if (!bus.walk_en) begin
      st_nx = IDLE;
    end else begin
      case (st)
        IDLE:    st_nx = hurry_zone ? HURRY : WALK;
        WALK:    if (hurry_zone)  st_nx = HURRY;
        HURRY:   if (!hurry_zone) st_nx = WALK;
        default: st_nx = IDLE;
      endcase
    end
  end

  // Animation and blink counters only run while the state is held steady.
  always_comb begin
    frame_nx = frame;
    fcnt_nx  = fcnt;
    bcnt_nx  = bcnt;
    vis_nx   = vis;
    if (st_nx == IDLE) begin
      frame_nx = 2'd0;
      fcnt_nx  = '0;
      bcnt_nx  = '0;
      vis_nx   = 1'b1;
    end else if (st_nx != st) begin
      fcnt_nx = '0;
      if (st_nx == HURRY) begin
        bcnt_nx = '0;
        vis_nx  = 1'b1;
      end
    end else if (sweep) begin
      if (fcnt == fcnt_lim) begin
        fcnt_nx  = '0;
        frame_nx = frame + 2'd1;
      end else begin
        fcnt_nx = fcnt + FW'(1);
      end
      if (st == HURRY) begin
        if (bcnt == BW'(BLINK_SWEEPS - 1)) begin
          bcnt_nx = '0;
          vis_nx  = ~vis;
        end else begin
          bcnt_nx = bcnt + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div    <= '0;
      row    <= 3'd0;
      vert_r <= 8'h01;
      hori_r <= 8'hFF;
      st     <= IDLE;
      frame  <= 2'd0;
      fcnt   <= '0;
      bcnt   <= '0;
      vis    <= 1'b1;
    end else begin
      if (row_end) begin
        div <= '0;
        row <= row + 3'd1;
      end else begin
        div <= div + DW'(1);
      end
      st     <= st_nx;
      frame  <= frame_nx;
      fcnt   <= fcnt_nx;
      bcnt   <= bcnt_nx;
      vis    <= vis_nx;
      vert_r <= 8'b1 << row;
      // Column data follows the new state so a dropped walk_en blanks at once.
      if (st_nx == IDLE || (st_nx == HURRY && !vis_nx)) begin
        hori_r <= 8'hFF;
      end else begin
        hori_r <= ~glyph(frame_nx, row);
      end
    end
  end

  assign bus.vert  = vert_r;
  assign bus.hori  = hori_r;
  assign bus.state = st;
  assign bus.frame = frame;

endmodule
